// File: rtl/config_loader_if.sv
// rtl/config_loader_if.sv - byte-stream handshake carrying configuration frames into config_loader
interface config_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/config_loader.sv
// rtl/config_loader.sv - frame parser writing 32-bit config words to NUM_TILES tiles
// Optional per-frame XOR checksum byte enabled by defining CFG_CHECKSUM_EN.
module config_loader #(
  parameter int NUM_TILES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  config_loader_if.slave       stream,
  input  logic                 err_clr,
  output logic [31:0]          config_data,
  output logic [NUM_TILES-1:0] config_en,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          frame_count
);

  localparam logic [8:0] TILE_LIMIT = 9'(NUM_TILES);

  typedef enum logic [1:0] {
    S_ADDR,
    S_DATA,
`ifdef CFG_CHECKSUM_EN
    S_CHK,
`endif
    S_WRITE
  } state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [7:0]  addr;
  logic [31:0] word;
`ifdef CFG_CHECKSUM_EN
  logic [7:0]  chk_acc;
`endif

  logic                 accept;
  logic                 last_accept;
  logic                 addr_ok;
  logic                 frame_ok;
  logic [31:0]          next_word;
  logic [NUM_TILES-1:0] en_dec;

  always_comb begin
    accept  = stream.in_valid && stream.in_ready;
    addr_ok = (addr == 8'hFF) || ({1'b0, addr} < TILE_LIMIT);
    en_dec  = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      en_dec[i] = (addr == 8'hFF) || (addr == 8'(i));
    end
`ifdef CFG_CHECKSUM_EN
    last_accept = accept && (state == S_CHK);
    next_word   = word;
    frame_ok    = addr_ok && (stream.in_data == chk_acc);
`else
    // Without a checksum the final data byte completes the word directly.
    last_accept = accept && (state == S_DATA) && (cnt == 2'd3);
    next_word   = {stream.in_data, word[23:0]};
    frame_ok    = addr_ok;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_ADDR;
      cnt             <= 2'd0;
      addr            <= 8'h00;
      word            <= 32'h0;
      config_data     <= 32'h0;
      config_en       <= '0;
      done            <= 1'b0;
      err             <= 1'b0;
      frame_count     <= 16'h0;
      stream.in_ready <= 1'b1;
`ifdef CFG_CHECKSUM_EN
      chk_acc         <= 8'h00;
`endif
    end else begin
      config_en <= '0;
      done      <= 1'b0;
      if (err_clr) err <= 1'b0;

      case (state)
        S_ADDR: begin
          if (accept) begin
            addr  <= stream.in_data;
            cnt   <= 2'd0;
            state <= S_DATA;
`ifdef CFG_CHECKSUM_EN
            chk_acc <= stream.in_data;
`endif
          end
        end
        S_DATA: begin
          if (accept) begin
            word[{cnt, 3'b000} +: 8] <= stream.in_data;
            cnt <= cnt + 2'd1;
`ifdef CFG_CHECKSUM_EN
            chk_acc <= chk_acc ^ stream.in_data;
            if (cnt == 2'd3) state <= S_CHK;
`endif
          end
        end
`ifdef CFG_CHECKSUM_EN
        S_CHK: ;
`endif
        S_WRITE: begin
          state           <= S_ADDR;
          stream.in_ready <= 1'b1;
        end
        default: state <= S_ADDR;
      endcase

      // Completing a frame overrides the per-state updates above; err set beats err_clr.
      if (last_accept) begin
        state           <= S_WRITE;
        stream.in_ready <= 1'b0;
        if (frame_ok) begin
          config_en   <= en_dec;
          config_data <= next_word;
          done        <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - scoreboard bench for config_loader (honours CFG_CHECKSUM_EN)
module tb_config_loader;
  localparam int NT = 16;
`ifdef CFG_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          err_clr = 1'b0;
  logic [31:0]   config_data;
  logic [NT-1:0] config_en;
  logic          done;
  logic          err;
  logic [15:0]   frame_count;

  config_loader_if bus ();

  config_loader #(.NUM_TILES(NT)) dut (
    .clk         (clk),
    .reset       (reset),
    .stream      (bus),
    .err_clr     (err_clr),
    .config_data (config_data),
    .config_en   (config_en),
    .done        (done),
    .err         (err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NT-1:0] en;
    logic [31:0]   data;
    logic [15:0]   fc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          low_cnt = 0;
  logic [15:0] fc_model = 16'h0;
  logic [31:0] last_data = 32'h0;

  // Every strobe or done pulse must match the next expected write, one cycle each.
  always @(negedge clk) begin
    if (bus.in_ready === 1'b0) low_cnt++;
    if (done === 1'b1) done_cnt++;
    if (config_en !== '0 || done !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: en=%h data=%h done=%b, required no write", config_en, config_data, done);
      end else begin
        mon_e = exp_q.pop_front();
        if (config_en !== mon_e.en || config_data !== mon_e.data || done !== 1'b1 || frame_count !== mon_e.fc) begin
          fails++;
          $display("FAIL write: en=%h data=%h done=%b fc=%0d, required en=%h data=%h done=1 fc=%0d",
                   config_en, config_data, done, frame_count, mon_e.en, mon_e.data, mon_e.fc);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] w, input bit bad_chk, input bit keep);
    logic [7:0]    b[6];
    logic [7:0]    x;
    logic [NT-1:0] en;
    bit            ok;
    b[0] = a;
    for (int i = 0; i < 4; i++) b[i+1] = w[8*i +: 8];
    x    = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
    b[5] = bad_chk ? (x ^ 8'h05) : x;
    ok   = ((a == 8'hFF) || (int'(a) < NT)) && !(CHK && bad_chk);
    if (ok) begin
      en = (a == 8'hFF) ? '1 : (NT'(1) << a);
      fc_model++;
      last_data = w;
      exp_q.push_back('{en, w, fc_model});
    end
    for (int i = 0; i < (CHK ? 6 : 5); i++) send_byte(b[i]);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    err_clr      = 1'b1;
    repeat (2) @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    err_clr      = 1'b0;
    fc_model     = 16'h0;
    last_data    = 32'h0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 6;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b, required 1", bus.in_ready); end
    if (config_en !== '0) begin fails++; $display("FAIL reset_en: got %h, required 0", config_en); end
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, required 0", done); end
    if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b, required 0", err); end
    if (frame_count !== 16'h0) begin fails++; $display("FAIL reset_fc: got %0d, required 0", frame_count); end
    if (config_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h, required 0", config_data); end
  endtask

  task automatic test_single();
    send_frame(8'h03, 32'h12345678, 1'b0, 1'b0);
    @(negedge clk);
    checks += 3;
    if (exp_q.size() != 0) begin fails++; $display("FAIL single_pending: got %0d, required 0", exp_q.size()); end
    if (frame_count !== 16'd1) begin fails++; $display("FAIL single_fc: got %0d, required 1", frame_count); end
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b, required 1", bus.in_ready); end
  endtask

  task automatic test_broadcast();
    send_frame(8'hFF, 32'h00000001, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks += 2;
    if (exp_q.size() != 0) begin fails++; $display("FAIL bcast_pending: got %0d, required 0", exp_q.size()); end
    if (config_data !== 32'h00000001) begin fails++; $display("FAIL bcast_hold: got %h, required 00000001", config_data); end
  endtask

  task automatic test_boundary();
    send_frame(8'h0F, 32'hCAFEF00D, 1'b0, 1'b0);
    send_frame(8'h00, 32'h0BADBEEF, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL boundary_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_invalid();
    send_frame(8'h10, 32'hDDCCBBAA, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1) begin fails++; $display("FAIL invalid_err: got %b, required 1", err); end
    @(negedge clk);
    checks += 2;
    if (config_data !== last_data) begin fails++; $display("FAIL invalid_hold: got %h, required %h", config_data, last_data); end
    if (frame_count !== fc_model) begin fails++; $display("FAIL invalid_fc: got %0d, required %0d", frame_count, fc_model); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_clr: got %b, required 0", err); end
    err_clr = 1'b1;
    send_frame(8'h20, 32'h11111111, 1'b0, 1'b0);
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b1) begin fails++; $display("FAIL set_wins: got %b, required 1", err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h02);
    send_byte(8'h11);
    apply_reset();
    send_frame(8'h05, 32'h55667788, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks += 2;
    if (exp_q.size() != 0) begin fails++; $display("FAIL midreset_pending: got %0d, required 0", exp_q.size()); end
    if (frame_count !== 16'd1) begin fails++; $display("FAIL midreset_fc: got %0d, required 1", frame_count); end
  endtask

`ifdef CFG_CHECKSUM_EN
  task automatic test_checksum();
    send_frame(8'h01, 32'h04030201, 1'b0, 1'b0);
    send_frame(8'h01, 32'h04030201, 1'b1, 1'b0);
    checks++;
    if (err !== 1'b1) begin fails++; $display("FAIL chk_err: got %b, required 1", err); end
    @(negedge clk);
    checks += 2;
    if (exp_q.size() != 0) begin fails++; $display("FAIL chk_pending: got %0d, required 0", exp_q.size()); end
    if (frame_count !== fc_model) begin fails++; $display("FAIL chk_fc: got %0d, required %0d", frame_count, fc_model); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    int low0;
    int done0;
    apply_reset();
    low0  = low_cnt;
    done0 = done_cnt;
    send_frame(8'h01, 32'hA1A2A3A4, 1'b0, 1'b1);
    send_frame(8'h07, 32'hB1B2B3B4, 1'b0, 1'b1);
    send_frame(8'hFF, 32'hC1C2C3C4, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks += 4;
    if (low_cnt - low0 != 3) begin fails++; $display("FAIL b2b_bubbles: got %0d, required 3", low_cnt - low0); end
    if (done_cnt - done0 != 3) begin fails++; $display("FAIL b2b_done: got %0d, required 3", done_cnt - done0); end
    if (frame_count !== 16'd3) begin fails++; $display("FAIL b2b_fc: got %0d, required 3", frame_count); end
    if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_pending: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_broadcast();
    test_boundary();
    test_invalid();
    test_reset_midframe();
`ifdef CFG_CHECKSUM_EN
    test_checksum();
`endif
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
